// File: rtl/phy_status_poller_pkg.sv
// Shared state encoding, speed codes and status-register bit positions for the
// MDIO PHY status poller.
package phy_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_NEXT = 2'd2
  } poll_state_t;

  localparam logic [1:0] SPD_10M   = 2'b00;
  localparam logic [1:0] SPD_100M  = 2'b01;
  localparam logic [1:0] SPD_1000M = 2'b10;

  localparam int LINK_BIT = 10;
  localparam int SPD_MSB  = 15;
  localparam int SPD_LSB  = 14;

  // PHY addresses are 5 bits on the wire, so base+channel wraps modulo 32.
  function automatic logic [4:0] phy_addr_of(input logic [4:0] base, input logic [4:0] ch);
    return base + ch;
  endfunction

endpackage

// File: rtl/phy_status_poller_timer.sv
// Enable-gated interval counter between polling sweeps; raises expire_o in the
// cycle the sweep may start and clears itself on that cycle.
module poll_interval_timer #(
  parameter int unsigned POLL_INTERVAL = 1_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic run_i,
  input  logic first_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_INTERVAL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The very first sweep after reset does not wait out a full interval.
  assign expire_o = run_i && (first_i || (count_q == CNT_LAST));

  always_comb begin
    count_d = count_q;
    if (run_i) begin
      count_d = expire_o ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/phy_status_poller.sv
// Sweeps NUM_CH PHYs over one shared MDIO master and holds decoded link/speed.
// Build option PHY_POLL_MASK_EN adds ch_mask to skip channels without an MDIO cycle.
module phy_status_poller
  import phy_poll_pkg::*;
#(
  parameter int unsigned NUM_CH        = 8,
  parameter logic [4:0]  PHY_ADDR_BASE = 5'd1,
  parameter logic [4:0]  STAT_REG      = 5'h11,
  parameter int unsigned POLL_INTERVAL = 1_000_000,
  parameter int unsigned ACK_TIMEOUT   = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
`ifdef PHY_POLL_MASK_EN
  input  logic [NUM_CH-1:0]     ch_mask,
`endif
  output logic                  mdio_req,
  output logic [4:0]            mdio_phy_addr,
  output logic [4:0]            mdio_reg_addr,
  input  logic                  mdio_ack,
  input  logic [15:0]           mdio_rdata,
  output logic [NUM_CH-1:0]     link,
  output logic [2*NUM_CH-1:0]   speed,
  output logic [NUM_CH-1:0]     timeout,
  output logic                  sweep_done
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  poll_state_t         state_q;
  logic [CH_W-1:0]     ch_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                first_q;
  logic                req_q;
  logic                done_q;
  logic [4:0]          phy_addr_q;
  logic [4:0]          reg_addr_q;
  logic [NUM_CH-1:0]   link_q;
  logic [2*NUM_CH-1:0] speed_q;
  logic [NUM_CH-1:0]   timeout_q;

  logic [NUM_CH-1:0]   mask_w;
  logic [CH_W-1:0]     nxt_ch;
  logic [CH_W:0]       sp_cur;
  logic [CH_W:0]       sp_nxt;
  logic                expire;
  logic                launch;
  logic                ack_hit;
  logic                wait_over;
  logic                unused_rdata;

`ifdef PHY_POLL_MASK_EN
  assign mask_w = ch_mask;
`else
  assign mask_w = '0;
`endif

  poll_interval_timer #(
    .POLL_INTERVAL (POLL_INTERVAL)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .run_i    ((state_q == ST_IDLE) && enable),
    .first_i  (first_q),
    .expire_o (expire)
  );

  assign ack_hit   = (state_q == ST_REQ) && mdio_ack;
  assign wait_over = (state_q == ST_REQ) && (wait_q == WAIT_LAST);
  // A channel is launched either at sweep start or after a non-final channel.
  assign launch    = expire || ((state_q == ST_NEXT) && (ch_q != LAST_CH));
  assign nxt_ch    = (state_q == ST_NEXT) ? ch_q + CH_W'(1) : '0;
  assign sp_cur    = {ch_q, 1'b0};
  assign sp_nxt    = {nxt_ch, 1'b0};
  assign unused_rdata = ^{mdio_rdata[13:11], mdio_rdata[9:0]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      wait_q     <= '0;
      first_q    <= 1'b1;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      phy_addr_q <= '0;
      reg_addr_q <= '0;
      link_q     <= '0;
      speed_q    <= '0;
      timeout_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_REQ: begin
          wait_q <= wait_q + WAIT_W'(1);
          // An ack landing on the expiry cycle still counts as a good read.
          if (ack_hit) begin
            link_q[ch_q]         <= mdio_rdata[LINK_BIT];
            speed_q[sp_cur +: 2] <= mdio_rdata[SPD_MSB:SPD_LSB];
            timeout_q[ch_q]      <= 1'b0;
            req_q                <= 1'b0;
            state_q              <= ST_NEXT;
          end else if (wait_over) begin
            link_q[ch_q]         <= 1'b0;
            speed_q[sp_cur +: 2] <= SPD_10M;
            timeout_q[ch_q]      <= 1'b1;
            req_q                <= 1'b0;
            state_q              <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (ch_q == LAST_CH) begin
            done_q  <= 1'b1;
            ch_q    <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
        end
      endcase

      if (launch) begin
        first_q <= 1'b0;
        ch_q    <= nxt_ch;
        // Masked channels pass straight through NEXT without touching MDIO.
        if (mask_w[nxt_ch]) begin
          link_q[nxt_ch]       <= 1'b0;
          speed_q[sp_nxt +: 2] <= SPD_10M;
          timeout_q[nxt_ch]    <= 1'b0;
          state_q              <= ST_NEXT;
        end else begin
          state_q    <= ST_REQ;
          req_q      <= 1'b1;
          phy_addr_q <= phy_addr_of(PHY_ADDR_BASE, 5'(nxt_ch));
          reg_addr_q <= STAT_REG;
          wait_q     <= '0;
        end
      end
    end
  end

  assign mdio_req      = req_q;
  assign mdio_phy_addr = phy_addr_q;
  assign mdio_reg_addr = reg_addr_q;
  assign link          = link_q;
  assign speed         = speed_q;
  assign timeout       = timeout_q;
  assign sweep_done    = done_q;

endmodule

// File: tb/tb_phy_status_poller.sv
// Bench for phy_status_poller: an MDIO responder with per-channel data, delay
// and no-ack settings, and a per-channel status model built from the read results.
module tb_phy_status_poller;

  localparam int NCH = 8;
  localparam int PI  = 40;
  localparam int AT  = 16;
  localparam logic [4:0] BASE = 5'd1;
  localparam logic [4:0] SREG = 5'h11;

  logic             clk = 1'b0;
  logic             rstn;
  logic             enable;
  logic             mdio_req;
  logic [4:0]       mdio_phy_addr;
  logic [4:0]       mdio_reg_addr;
  logic             mdio_ack;
  logic [15:0]      mdio_rdata;
  logic [NCH-1:0]   link;
  logic [2*NCH-1:0] speed;
  logic [NCH-1:0]   timeout;
  logic             sweep_done;

  always #5 clk = ~clk;

  phy_status_poller #(
    .NUM_CH        (NCH),
    .PHY_ADDR_BASE (BASE),
    .STAT_REG      (SREG),
    .POLL_INTERVAL (PI),
    .ACK_TIMEOUT   (AT)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .mdio_req      (mdio_req),
    .mdio_phy_addr (mdio_phy_addr),
    .mdio_reg_addr (mdio_reg_addr),
    .mdio_ack      (mdio_ack),
    .mdio_rdata    (mdio_rdata),
    .link          (link),
    .speed         (speed),
    .timeout       (timeout),
    .sweep_done    (sweep_done)
  );

  typedef struct {
    logic [4:0]       addr;
    logic [4:0]       rg;
    int               rise;
    int               dur;
    logic [NCH-1:0]   lnk;
    logic [2*NCH-1:0] spd;
    logic [NCH-1:0]   to;
  } rec_t;

  rec_t        log_q[$];
  logic [15:0] rsp_data[NCH];
  int          rsp_dly[NCH];
  bit          rsp_noack[NCH];
  bit          exp_link[NCH];
  bit [1:0]    exp_spd[NCH];
  bit          exp_to[NCH];
  int          spur_req;
  int          spur_served;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc;
  int          n_pass;
  int          n_total;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (sweep_done === 1'b1) done_cnt <= done_cnt + 1;

  // MDIO master stand-in: acks each request after rsp_dly cycles, or never.
  initial begin : responder
    rec_t r;
    int c;
    mdio_ack = 1'b0;
    mdio_rdata = '0;
    spur_served = 0;
    forever begin
      @(posedge clk); #1;
      if (spur_served != spur_req) begin
        mdio_ack = 1'b1; mdio_rdata = 16'hFFFF;
        @(posedge clk); #1;
        mdio_ack = 1'b0; mdio_rdata = '0;
        spur_served = spur_req;
      end else if (mdio_req === 1'b1) begin
        r.addr = mdio_phy_addr; r.rg = mdio_reg_addr; r.rise = cyc; r.dur = 1;
        c = int'(mdio_phy_addr) - int'(BASE);
        if (c >= 0 && c < NCH && !rsp_noack[c]) begin
          for (int k = 0; k < rsp_dly[c]; k++) begin
            @(posedge clk); #1;
            if (mdio_req === 1'b1) r.dur = r.dur + 1;
          end
          mdio_ack = 1'b1; mdio_rdata = rsp_data[c];
          @(posedge clk); #1;
          mdio_ack = 1'b0; mdio_rdata = '0;
        end else begin
          for (int k = 0; k < 4*AT; k++) begin
            @(posedge clk); #1;
            if (mdio_req === 1'b1) r.dur = r.dur + 1;
            else break;
          end
        end
        r.lnk = link; r.spd = speed; r.to = timeout;
        log_q.push_back(r);
      end
    end
  end

  function automatic void apply_ch(input int c);
    if (rsp_noack[c]) begin
      exp_link[c] = 1'b0; exp_spd[c] = 2'b00; exp_to[c] = 1'b1;
    end else begin
      exp_link[c] = rsp_data[c][10]; exp_spd[c] = rsp_data[c][15:14]; exp_to[c] = 1'b0;
    end
  endfunction

  function automatic logic [NCH-1:0] m_link();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = exp_link[i];
    return v;
  endfunction

  function automatic logic [2*NCH-1:0] m_spd();
    logic [2*NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[2*i +: 2] = exp_spd[i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] m_to();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = exp_to[i];
    return v;
  endfunction

  function automatic int exp_gap(input int c);
    return (rsp_noack[c] ? AT : rsp_dly[c] + 1) + 1;
  endfunction

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (sweep_done === 1'b1) begin ok = 1'b1; done_cyc = cyc; break; end
    end
  endtask

  task automatic wait_req(input int budget, output bit ok, output int at);
    ok = 1'b0; at = -1;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (mdio_req === 1'b1) begin ok = 1'b1; at = cyc; break; end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b0; spur_req = 0;
    repeat (3) @(posedge clk); #1;
    n_total++; if (mdio_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", mdio_req); else n_pass++;
    n_total++; if (mdio_phy_addr !== 5'd0 || mdio_reg_addr !== 5'd0)
      $display("FAIL rst_addr got=%h/%h exp=0/0", mdio_phy_addr, mdio_reg_addr); else n_pass++;
    n_total++; if (link !== '0 || speed !== '0 || timeout !== '0)
      $display("FAIL rst_status got=%h/%h/%h exp=0", link, speed, timeout); else n_pass++;
    n_total++; if (sweep_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", sweep_done); else n_pass++;
    rstn = 1'b1;
    repeat (10) @(posedge clk); #1;
    n_total++; if (mdio_req !== 1'b0 || log_q.size() != 0)
      $display("FAIL idle_disabled req=%b reqs=%0d exp=0", mdio_req, log_q.size()); else n_pass++;
  endtask

  task automatic test_basic_sweep();
    bit ok;
    int t_en, d0;
    for (int c = 0; c < NCH; c++) begin
      rsp_data[c] = 16'h8400; rsp_dly[c] = 3; rsp_noack[c] = 1'b0;
    end
    log_q.delete(); d0 = done_cnt;
    enable = 1'b1; t_en = cyc;
    wait_done(400, ok);
    n_total++; if (!ok) $display("FAIL basic_done got=none exp=pulse"); else n_pass++;
    n_total++; if (log_q.size() != NCH) $display("FAIL basic_nreq got=%0d exp=%0d", log_q.size(), NCH); else n_pass++;
    if (log_q.size() > 0) begin
      n_total++; if (log_q[0].rise != t_en + 1)
        $display("FAIL basic_first_start got=%0d exp=%0d", log_q[0].rise, t_en + 1); else n_pass++;
    end
    for (int i = 0; i < NCH; i++) begin
      apply_ch(i);
      if (i < log_q.size()) begin
        n_total++; if (log_q[i].addr !== 5'(BASE + i) || log_q[i].rg !== SREG)
          $display("FAIL basic_addr ch%0d got=%h/%h exp=%h/%h", i, log_q[i].addr, log_q[i].rg, 5'(BASE + i), SREG);
        else n_pass++;
        n_total++; if (log_q[i].lnk !== m_link() || log_q[i].spd !== m_spd())
          $display("FAIL basic_update ch%0d got=%h/%h exp=%h/%h", i, log_q[i].lnk, log_q[i].spd, m_link(), m_spd());
        else n_pass++;
        if (i > 0) begin
          n_total++; if (log_q[i].rise - log_q[i-1].rise != 5)
            $display("FAIL basic_gap ch%0d got=%0d exp=5", i, log_q[i].rise - log_q[i-1].rise); else n_pass++;
        end
      end
    end
    n_total++; if (link !== 8'hFF || speed !== 16'hAAAA || timeout !== 8'h00)
      $display("FAIL basic_final got=%h/%h/%h exp=ff/aaaa/00", link, speed, timeout); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (sweep_done !== 1'b0 || done_cnt - d0 != 1)
      $display("FAIL basic_done_pulse done=%b count=%0d exp=0/1", sweep_done, done_cnt - d0); else n_pass++;
  endtask

  task automatic test_random_sweeps();
    bit ok;
    int prev;
    for (int s = 0; s < 3; s++) begin
      for (int c = 0; c < NCH; c++) begin
        rsp_data[c]  = 16'($urandom_range(0, 65535));
        rsp_dly[c]   = $urandom_range(0, 5);
        rsp_noack[c] = (s == 0) ? (c == 3) : ((s == 2) ? ($urandom_range(0, 3) == 0) : 1'b0);
      end
      log_q.delete(); prev = done_cyc;
      wait_done(PI + NCH*(AT + 2) + 50, ok);
      n_total++; if (!ok) $display("FAIL rnd%0d_done got=none exp=pulse", s); else n_pass++;
      n_total++; if (log_q.size() != NCH) $display("FAIL rnd%0d_nreq got=%0d exp=%0d", s, log_q.size(), NCH); else n_pass++;
      if (log_q.size() > 0) begin
        n_total++; if (log_q[0].rise - prev != PI)
          $display("FAIL rnd%0d_interval got=%0d exp=%0d", s, log_q[0].rise - prev, PI); else n_pass++;
      end
      for (int i = 0; i < NCH; i++) begin
        apply_ch(i);
        if (i < log_q.size()) begin
          n_total++; if (log_q[i].addr !== 5'(BASE + i) || log_q[i].rg !== SREG)
            $display("FAIL rnd%0d_addr ch%0d got=%h/%h exp=%h/%h", s, i, log_q[i].addr, log_q[i].rg, 5'(BASE + i), SREG);
          else n_pass++;
          n_total++; if (log_q[i].lnk !== m_link() || log_q[i].spd !== m_spd() || log_q[i].to !== m_to())
            $display("FAIL rnd%0d_update ch%0d got=%h/%h/%h exp=%h/%h/%h", s, i,
                     log_q[i].lnk, log_q[i].spd, log_q[i].to, m_link(), m_spd(), m_to());
          else n_pass++;
          if (rsp_noack[i]) begin
            n_total++; if (log_q[i].dur != AT)
              $display("FAIL rnd%0d_req_hold ch%0d got=%0d exp=%0d", s, i, log_q[i].dur, AT); else n_pass++;
          end
          if (i > 0) begin
            n_total++; if (log_q[i].rise - log_q[i-1].rise != exp_gap(i-1))
              $display("FAIL rnd%0d_gap ch%0d got=%0d exp=%0d", s, i, log_q[i].rise - log_q[i-1].rise, exp_gap(i-1));
            else n_pass++;
          end
        end
      end
      n_total++; if (link !== m_link() || speed !== m_spd() || timeout !== m_to())
        $display("FAIL rnd%0d_final got=%h/%h/%h exp=%h/%h/%h", s, link, speed, timeout, m_link(), m_spd(), m_to());
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    bit ok;
    int t, t_en;
    for (int c = 0; c < NCH; c++) begin
      rsp_data[c] = 16'($urandom_range(0, 65535)); rsp_dly[c] = $urandom_range(0, 4); rsp_noack[c] = 1'b0;
    end
    log_q.delete();
    wait_req(PI + 10, ok, t);
    n_total++; if (!ok) $display("FAIL endrop_start got=none exp=req"); else n_pass++;
    enable = 1'b0;
    wait_done(NCH*10 + 50, ok);
    n_total++; if (!ok || log_q.size() != NCH)
      $display("FAIL endrop_finish done=%b reqs=%0d exp=1/%0d", ok, log_q.size(), NCH); else n_pass++;
    for (int c = 0; c < NCH; c++) apply_ch(c);
    n_total++; if (link !== m_link() || speed !== m_spd() || timeout !== m_to())
      $display("FAIL endrop_status got=%h/%h/%h exp=%h/%h/%h", link, speed, timeout, m_link(), m_spd(), m_to());
    else n_pass++;
    repeat (3*PI) @(posedge clk); #1;
    n_total++; if (log_q.size() != NCH || mdio_req !== 1'b0)
      $display("FAIL endrop_quiet reqs=%0d req=%b exp=%0d/0", log_q.size(), mdio_req, NCH); else n_pass++;
    for (int c = 0; c < NCH; c++) rsp_data[c] = 16'($urandom_range(0, 65535));
    log_q.delete();
    enable = 1'b1; repeat (10) @(posedge clk); #1;
    enable = 1'b0; repeat (20) @(posedge clk); #1;
    enable = 1'b1; t_en = cyc;
    wait_req(PI + 10, ok, t);
    n_total++; if (!ok || t != t_en + PI - 10)
      $display("FAIL endrop_frozen_count got=%0d exp=%0d", t, t_en + PI - 10); else n_pass++;
    wait_done(NCH*10 + 50, ok);
    enable = 1'b0;
    for (int c = 0; c < NCH; c++) apply_ch(c);
    n_total++; if (!ok || link !== m_link() || speed !== m_spd() || timeout !== m_to())
      $display("FAIL endrop_resume done=%b got=%h/%h/%h exp=%h/%h/%h", ok, link, speed, timeout, m_link(), m_spd(), m_to());
    else n_pass++;
  endtask

  task automatic test_spurious_ack();
    bit ok;
    log_q.delete();
    spur_req = spur_req + 1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (spur_served == spur_req) begin ok = 1'b1; break; end
    end
    n_total++; if (!ok) $display("FAIL spur_issue got=pending exp=served"); else n_pass++;
    repeat (2) @(posedge clk); #1;
    n_total++; if (link !== m_link() || speed !== m_spd() || timeout !== m_to())
      $display("FAIL spur_status got=%h/%h/%h exp=%h/%h/%h", link, speed, timeout, m_link(), m_spd(), m_to());
    else n_pass++;
    n_total++; if (mdio_req !== 1'b0 || log_q.size() != 0)
      $display("FAIL spur_req req=%b reqs=%0d exp=0/0", mdio_req, log_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t;
    for (int c = 0; c < NCH; c++) begin
      rsp_data[c] = 16'hC400; rsp_dly[c] = 6; rsp_noack[c] = 1'b0;
    end
    log_q.delete();
    enable = 1'b1;
    wait_req(PI + 10, ok, t);
    n_total++; if (!ok) $display("FAIL rstmid_start got=none exp=req"); else n_pass++;
    rstn = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    n_total++; if (mdio_req !== 1'b0 || mdio_phy_addr !== 5'd0)
      $display("FAIL rstmid_drop req=%b addr=%h exp=0/00", mdio_req, mdio_phy_addr); else n_pass++;
    n_total++; if (link !== '0 || speed !== '0 || timeout !== '0)
      $display("FAIL rstmid_clear got=%h/%h/%h exp=0", link, speed, timeout); else n_pass++;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (12) @(posedge clk); #1;
    n_total++; if (link !== '0 || speed !== '0 || timeout !== '0 || mdio_req !== 1'b0)
      $display("FAIL rstmid_late_ack got=%h/%h/%h req=%b exp=0", link, speed, timeout, mdio_req); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    done_cyc = 0;
    for (int c = 0; c < NCH; c++) begin
      exp_link[c] = 1'b0; exp_spd[c] = 2'b00; exp_to[c] = 1'b0;
      rsp_data[c] = '0; rsp_dly[c] = 0; rsp_noack[c] = 1'b0;
    end
    test_reset();
    test_basic_sweep();
    test_random_sweeps();
    test_enable_drop();
    test_spurious_ack();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
